// File: rtl/pipe_fifo2.sv
// pipe_fifo2: two-entry pipeline FIFO. The head register (data0) drives D_OUT
// directly and the tail register (data1) holds the second entry. FULL_N and
// EMPTY_N are decoded from the registered occupancy count only. An enqueue
// while full is discarded, and there is no bypass path at full. When guarded
// is nonzero, protocol violations set a sticky ERR flag that only RST clears.
module pipe_fifo2 #(
    parameter int width   = 1,
    parameter int guarded = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    output logic [width-1:0] D_OUT,
    input  logic             DEQ,
    output logic             EMPTY_N,
    input  logic             CLR,
    output logic             ERR
);

    logic [1:0]       count_q, count_d;
    logic [width-1:0] data0_q, data0_d;
    logic [width-1:0] data1_q, data1_d;
    logic             err_q, err_d;
    logic             violation;

    // Next-state decode: CLR flushes the occupancy and leaves the data in place; otherwise ENQ/DEQ act on the current count
    always_comb begin
        count_d   = count_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        err_d     = err_q;
        violation = 1'b0;

        if (CLR) begin
            count_d = 2'd0;
        end else begin
            violation = (ENQ && (count_q == 2'd2)) || (DEQ && (count_q == 2'd0));
            case (count_q)
                2'd0: begin
                    // A dequeue from empty is ignored, but a simultaneous enqueue still lands in the head
                    if (ENQ) begin
                        data0_d = D_IN;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    case ({ENQ, DEQ})
                        2'b10: begin
                            data1_d = D_IN;
                            count_d = 2'd2;
                        end
                        2'b01: begin
                            count_d = 2'd0;
                        end
                        2'b11: begin
                            // The old head leaves and the new word becomes the head, so occupancy stays at one
                            data0_d = D_IN;
                        end
                        default: begin
                            count_d = count_q;
                        end
                    endcase
                end
                2'd2: begin
                    // An enqueue at full is dropped even when a dequeue frees a slot in the same cycle
                    if (DEQ) begin
                        data0_d = data1_q;
                        count_d = 2'd1;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end

        if ((guarded != 0) && violation) begin
            err_d = 1'b1;
        end
    end

    // State registers with a synchronous reset that clears occupancy, data and the error flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            err_q   <= err_d;
        end
    end

    // Status flags and the output word decode from registered state only
    always_comb begin
        FULL_N  = (count_q != 2'd2);
        EMPTY_N = (count_q != 2'd0);
        D_OUT   = data0_q;
        ERR     = err_q;
    end

endmodule

// File: doc/pipe_fifo2.md
PIPE_FIFO2 -- requirements
Module: pipe_fifo2

Interface
REQ-001 SHALL have parameter: width, 1, data bits per entry.
REQ-002 SHALL have parameter: guarded, 1, 1 = detect and flag protocol violations on ERR; 0 = ERR tied 0.
REQ-003 SHALL have port: CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: D_IN  input  width  enqueue data.
REQ-006 SHALL have port: ENQ  input  1  enqueue request; legal only while FULL_N=1.
REQ-007 SHALL have port: FULL_N  output  1  registered; 1 = at least one free entry.
REQ-008 SHALL have port: D_OUT  output  width  head entry; driven directly from head register.
REQ-009 SHALL have port: DEQ  input  1  dequeue request; legal only while EMPTY_N=1.
REQ-010 SHALL have port: EMPTY_N  output  1  registered; 1 = at least one valid entry.
REQ-011 SHALL have port: CLR  input  1  synchronous flush.
REQ-012 SHALL have port: ERR  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL hold two entries: head register data0 (drives D_OUT) and tail register data1; occupancy count in {0,1,2}.
REQ-014 SHALL derive FULL_N = (count != 2) and EMPTY_N = (count != 0) from registered state only; no combinational path from ENQ/DEQ to FULL_N/EMPTY_N.
REQ-015 SHALL make enqueued data visible on D_OUT with EMPTY_N=1 one cycle after the ENQ edge when the FIFO was empty.
REQ-016 SHALL, count 0, ENQ: data0<=D_IN, count->1.
REQ-017 SHALL, count 1, ENQ only: data1<=D_IN, count->2.
REQ-018 SHALL, count 1, DEQ only: count->0; data0 unchanged.
REQ-019 SHALL, count 1, ENQ and DEQ same cycle: data0<=D_IN, count stays 1.
REQ-020 SHALL, count 2, DEQ only: data0<=data1, count->1.
REQ-021 SHALL, count 2, ENQ (with or without DEQ): discard the enqueue (no bypass at full); DEQ still honoured.
REQ-022 SHALL, count 0, DEQ: ignore the dequeue; state unchanged; simultaneous ENQ still honoured.
REQ-023 SHALL treat CLR as priority over ENQ/DEQ: count->0 next cycle, ENQ/DEQ in that cycle ignored, data registers unchanged.
REQ-024 SHALL, when guarded=1, set ERR on any cycle with ENQ=1 while FULL_N=0, or DEQ=1 while EMPTY_N=0 (CLR=0); ERR then holds 1 until RST.
REQ-025 SHALL not clear ERR on CLR.
REQ-026 SHALL leave data0/data1 unchanged when not written (no toggling on idle cycles).

Reset
REQ-027 SHALL, while RST=1 at posedge CLK, set count=0, data0=data1=0, ERR=0; FULL_N=1, EMPTY_N=0, D_OUT=0 from the next cycle.
REQ-028 SHALL give RST priority over CLR, ENQ and DEQ; any in-flight contents are lost.
REQ-029 SHALL have no asynchronous reset path; RST asserted between edges has no effect until the next posedge.

Verification
REQ-030 SHALL pass: reset, ENQ D_IN=0xA5 (width=8) one cycle -> next cycle EMPTY_N=1, FULL_N=1, D_OUT=0xA5.
REQ-031 SHALL pass: ENQ 0x11 then 0x22 back-to-back -> FULL_N=0; DEQ -> D_OUT=0x22, FULL_N=1; DEQ -> EMPTY_N=0; ERR=0 throughout.
REQ-032 SHALL pass: count 1 holding 0x11, ENQ 0x33 with DEQ same cycle -> count 1, D_OUT=0x33, FULL_N=1.
REQ-033 SHALL pass: full with 0x11,0x22, ENQ 0x44 -> contents unchanged, ERR=1; DEQ from empty after drain -> ERR stays 1; RST -> ERR=0.
REQ-034 SHALL pass: full FIFO, CLR with ENQ=DEQ=1 -> next cycle EMPTY_N=0, FULL_N=1, ERR=0.
REQ-035 SHALL pass: RST asserted mid-stream with ENQ=1 -> next cycle EMPTY_N=0, D_OUT=0, FULL_N=1.
